// File: rtl/reservation_station_pkg.sv
// Shared widths, operation codes and defaults for the reservation station and its neighbours.
package reservation_station_pkg;

    localparam int unsigned OPE_WIDTH        = 6;
    localparam int unsigned DEFAULT_ROB_ID_W = 4;
    localparam int unsigned DEFAULT_RS_SIZE  = 8;
    // ROB tag 0 means the operand value is already present.
    localparam int unsigned NON_DEPENDENT    = 0;

    typedef enum logic [OPE_WIDTH-1:0] {
        OpNop, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra, OpSlt, OpSltu,
        OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu, OpLui, OpAuipc, OpJal, OpJalr
    } ope_e;

endpackage

// File: rtl/rs_priority_encoder.sv
// Lowest-set-bit finder: index of the least significant 1 plus a found flag.
module rs_priority_encoder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     found
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = $clog2(WIDTH)'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU/branch reservation station: holds dispatched instructions, snoops both CDBs and
// issues the lowest-index ready entry each cycle.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned RS_SIZE  = DEFAULT_RS_SIZE,
    parameter int unsigned ROB_ID_W = DEFAULT_ROB_ID_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 mispredict,
    input  logic                 enable_from_dispatcher,
    input  logic [31:0]          Vj_from_dispatcher,
    input  logic [31:0]          Vk_from_dispatcher,
    input  logic [ROB_ID_W-1:0]  Qj_from_dispatcher,
    input  logic [ROB_ID_W-1:0]  Qk_from_dispatcher,
    input  logic [OPE_WIDTH-1:0] type_from_dispatcher,
    input  logic [31:0]          imm_from_dispatcher,
    input  logic [31:0]          pc_from_dispatcher,
    input  logic [ROB_ID_W-1:0]  rob_id_from_dispatcher,
    output logic                 full_to_dispatcher,
    input  logic                 enable_cdb_rs,
    input  logic                 enable_cdb_lsb,
    input  logic [ROB_ID_W-1:0]  cdb_rs_rob_id,
    input  logic [ROB_ID_W-1:0]  cdb_lsb_rob_id,
    input  logic [31:0]          cdb_rs_value,
    input  logic [31:0]          cdb_lsb_value,
    output logic                 enable_to_alu,
    output logic [OPE_WIDTH-1:0] type_to_alu,
    output logic [31:0]          Vj_to_alu,
    output logic [31:0]          Vk_to_alu,
    output logic [31:0]          imm_to_alu,
    output logic [31:0]          pc_to_alu,
    output logic [ROB_ID_W-1:0]  rob_id_to_alu
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [ROB_ID_W-1:0] NO_DEP = ROB_ID_W'(NON_DEPENDENT);

    typedef struct packed {
        logic [OPE_WIDTH-1:0] op;
        logic [31:0]          vj;
        logic [31:0]          vk;
        logic [ROB_ID_W-1:0]  qj;
        logic [ROB_ID_W-1:0]  qk;
        logic [31:0]          imm;
        logic [31:0]          pc;
        logic [ROB_ID_W-1:0]  rob_id;
    } entry_t;

    entry_t              ent_q [RS_SIZE];
    logic [RS_SIZE-1:0]  valid_q;
    logic [RS_SIZE-1:0]  free_vec;
    logic [RS_SIZE-1:0]  ready_vec;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    ready_idx;
    logic                free_found;
    logic                ready_found;
    logic [CNT_W-1:0]    count;
    entry_t              ins_ent;

    // Resolve one operand against both buses; the LSB bus is checked last so it wins.
    function automatic logic [ROB_ID_W+31:0] resolve(
        input logic [ROB_ID_W-1:0] q,
        input logic [31:0]         v,
        input logic                rs_en,
        input logic [ROB_ID_W-1:0] rs_tag,
        input logic [31:0]         rs_val,
        input logic                lsb_en,
        input logic [ROB_ID_W-1:0] lsb_tag,
        input logic [31:0]         lsb_val
    );
        logic [ROB_ID_W+31:0] r;
        r = {q, v};
        if (q != NO_DEP) begin
            if (rs_en && q == rs_tag)   r = {NO_DEP, rs_val};
            if (lsb_en && q == lsb_tag) r = {NO_DEP, lsb_val};
        end
        return r;
    endfunction

    always_comb begin
        free_vec  = ~valid_q;
        ready_vec = '0;
        count     = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            ready_vec[i] = valid_q[i] && ent_q[i].qj == NO_DEP && ent_q[i].qk == NO_DEP;
            count        = count + CNT_W'(valid_q[i]);
        end
    end

    // One slot of slack covers the dispatcher's registered view of this flag.
    assign full_to_dispatcher = (count >= CNT_W'(RS_SIZE - 1));

    always_comb begin
        ins_ent        = '0;
        ins_ent.op     = type_from_dispatcher;
        ins_ent.imm    = imm_from_dispatcher;
        ins_ent.pc     = pc_from_dispatcher;
        ins_ent.rob_id = rob_id_from_dispatcher;
        {ins_ent.qj, ins_ent.vj} = resolve(Qj_from_dispatcher, Vj_from_dispatcher,
            enable_cdb_rs, cdb_rs_rob_id, cdb_rs_value,
            enable_cdb_lsb, cdb_lsb_rob_id, cdb_lsb_value);
        {ins_ent.qk, ins_ent.vk} = resolve(Qk_from_dispatcher, Vk_from_dispatcher,
            enable_cdb_rs, cdb_rs_rob_id, cdb_rs_value,
            enable_cdb_lsb, cdb_lsb_rob_id, cdb_lsb_value);
    end

    rs_priority_encoder #(.WIDTH(RS_SIZE)) u_free_enc (
        .vec   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_priority_encoder #(.WIDTH(RS_SIZE)) u_ready_enc (
        .vec   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q       <= '0;
            enable_to_alu <= 1'b0;
            type_to_alu   <= '0;
            Vj_to_alu     <= '0;
            Vk_to_alu     <= '0;
            imm_to_alu    <= '0;
            pc_to_alu     <= '0;
            rob_id_to_alu <= '0;
        end else if (rdy) begin
            if (mispredict) begin
                valid_q       <= '0;
                enable_to_alu <= 1'b0;
            end else begin
                for (int i = 0; i < int'(RS_SIZE); i++) begin
                    if (valid_q[i]) begin
                        {ent_q[i].qj, ent_q[i].vj} <= resolve(ent_q[i].qj, ent_q[i].vj,
                            enable_cdb_rs, cdb_rs_rob_id, cdb_rs_value,
                            enable_cdb_lsb, cdb_lsb_rob_id, cdb_lsb_value);
                        {ent_q[i].qk, ent_q[i].vk} <= resolve(ent_q[i].qk, ent_q[i].vk,
                            enable_cdb_rs, cdb_rs_rob_id, cdb_rs_value,
                            enable_cdb_lsb, cdb_lsb_rob_id, cdb_lsb_value);
                    end
                end
                enable_to_alu <= ready_found;
                if (ready_found) begin
                    type_to_alu        <= ent_q[ready_idx].op;
                    Vj_to_alu          <= ent_q[ready_idx].vj;
                    Vk_to_alu          <= ent_q[ready_idx].vk;
                    imm_to_alu         <= ent_q[ready_idx].imm;
                    pc_to_alu          <= ent_q[ready_idx].pc;
                    rob_id_to_alu      <= ent_q[ready_idx].rob_id;
                    valid_q[ready_idx] <= 1'b0;
                end
                // free_vec comes from pre-edge state, so a slot issued now is not reused now.
                if (enable_from_dispatcher && free_found) begin
                    ent_q[free_idx]   <= ins_ent;
                    valid_q[free_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Holds ALU/branch instructions from the dispatcher until their source operands are available, then issues one ready instruction per cycle to the ALU.
- Sits directly downstream of the dispatcher and snoops both CDB buses (RS/ALU result and LSB result) to resolve pending operands.
- Loads and stores bypass this block and go to the LSB.

Parameters:
- RS_SIZE, 8, number of entries (power of two, ≥4)
- ROB_ID_W, 4, ROB tag width; tag 0 is reserved as NON_DEPENDENT (no producer)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- rdy  in  1  global ready; low = freeze all state and outputs
- mispredict  in  1  flush from ROB
- enable_from_dispatcher  in  1  insert request, valid for one cycle
- Vj_from_dispatcher, Vk_from_dispatcher  in  32  operand values
- Qj_from_dispatcher, Qk_from_dispatcher  in  ROB_ID_W  operand tags (0 = value valid)
- type_from_dispatcher  in  OPE_WIDTH  operation code
- imm_from_dispatcher  in  32  immediate
- pc_from_dispatcher  in  32  instruction pc
- rob_id_from_dispatcher  in  ROB_ID_W  destination ROB tag
- full_to_dispatcher  out  1  back-pressure
- enable_cdb_rs, enable_cdb_lsb  in  1  CDB broadcast valid
- cdb_rs_rob_id, cdb_lsb_rob_id  in  ROB_ID_W  broadcast tags
- cdb_rs_value, cdb_lsb_value  in  32  broadcast values
- enable_to_alu  out  1  issue valid, one cycle
- type_to_alu  out  OPE_WIDTH
- Vj_to_alu, Vk_to_alu, imm_to_alu, pc_to_alu  out  32
- rob_id_to_alu  out  ROB_ID_W

Behaviour:
- Reset (rst=0 at posedge): all valid bits cleared; enable_to_alu=0; all other registered outputs 0; full_to_dispatcher=0.
- Entry fields: valid, type, Vj, Vk, Qj, Qk, imm, pc, rob_id.
- Insert:
  - When enable_from_dispatcher=1, the payload is written into the lowest-index free entry at the next posedge.
  - Same-cycle CDB forwarding on insert: if Qj_from_dispatcher≠0 and it matches an active CDB tag, store Vj=CDB value and Qj=0. Same rule for k. If both CDBs match (must not happen), the LSB bus wins.
- Snoop: every cycle, each valid entry with Qj (or Qk) equal to an active CDB tag captures the value and clears the tag to 0.
- Ready: valid && Qj==0 && Qk==0, evaluated on stored state only. An entry woken by the CDB in cycle N is issuable no earlier than cycle N+1.
- Issue:
  - Each cycle, the lowest-index ready entry is selected and its fields are registered to the *_to_alu outputs, with enable_to_alu=1 for one cycle. Its valid bit is cleared at the same edge.
  - If no entry is ready, enable_to_alu=0 (payload outputs may hold stale values).
  - Issue latency: an inserted entry with both tags 0 appears on the ALU port 2 edges after enable_from_dispatcher is sampled.
- Free/reuse: a slot freed by issue in cycle N is allocatable from cycle N+1, not the same edge.
- full_to_dispatcher:
  - Combinational from the valid count: 1 when free entries ≤1. This covers the dispatcher's one-cycle registered latency.
  - Insert while zero entries are free is a protocol violation: the request is dropped and the bench asserts it never happens.
- mispredict=1 at posedge (with rst=1): all valid bits cleared, enable_to_alu=0, and any same-cycle insert is discarded. Flush has priority over insert, issue and snoop.
- rdy=0: no insert, snoop, issue or flush takes effect; all state and outputs hold. Reset still applies regardless of rdy.
- Priority per edge: reset > rdy hold > mispredict > {insert, snoop, issue} concurrently.

Decomposition:
- Shared package/define file holds: OPE_WIDTH, operation codes, ROB_ID_W, NON_DEPENDENT=0, RS_SIZE default.
- One natural sub-module: rs_priority_encoder (lowest-set-bit index plus found flag, parameterised width). It is instantiated twice: once for the free-slot vector and once for the ready vector.

Test Plan:
- Reset then insert ADD, rob_id=3, Vj=5, Vk=7, Qj=Qk=0 → two edges later enable_to_alu=1, Vj=5, Vk=7, rob_id=3, then enable_to_alu=0.
- Insert rob_id=4 with Qj=2; next cycle enable_cdb_rs=1, tag 2, value 0x10 → issue the cycle after, with Vj=0x10; no issue before the broadcast.
- Insert with Qk=6 while cdb_lsb broadcasts tag 6 value 0xAB in the same cycle → entry stored ready, issued with Vk=0xAB.
- Fill 7 non-ready entries → full_to_dispatcher=1 after the 7th. Insert 8th; no data loss. Broadcast wakes entries 0 and 5 together → issue index 0 then index 5 on consecutive cycles.
- Occupy 4 entries, assert mispredict with a concurrent insert → all empty, enable_to_alu=0, full=0, later broadcasts cause no issue.
- Hold rdy=0 for 3 cycles with a ready entry and a CDB broadcast → no issue or capture; issue resumes the cycle after rdy returns. rst=0 during rdy=0 → cleared.
